// File: rtl/gemm_bus_slave.sv
// gemm_bus_slave: memory-mapped register window that stages GEMM tile
// descriptors and queues them for the compute engine.
// Optional feature macro: GEMM_CMD_PERF_EN adds a busy-cycle counter
// readable at offset 32; without it offset 32 reads 0.
module gemm_bus_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int          QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        system_bus_en,
    input  logic        system_bus_rdwr,
    input  logic [31:0] system_bus_addr,
    input  logic [31:0] system_bus_wr_data,
    output logic [31:0] system_bus_rd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_a_addr,
    output logic [31:0] cmd_b_addr,
    output logic [31:0] cmd_c_addr,
    output logic [31:0] cmd_a_stride,
    output logic [31:0] cmd_b_stride,
    output logic        cmd_first,
    output logic        cmd_last,
    output logic [4:0]  cmd_msize,
    output logic [4:0]  cmd_ksize,
    output logic [4:0]  cmd_nsize,
    input  logic        gemm_busy
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef struct packed {
        logic [31:0] a_addr;
        logic [31:0] b_addr;
        logic [31:0] c_addr;
        logic [31:0] a_stride;
        logic [31:0] b_stride;
        logic        first;
        logic        last;
        logic [4:0]  msize;
        logic [4:0]  ksize;
        logic [4:0]  nsize;
    } desc_t;

    desc_t          mem [QDEPTH];
    desc_t          stage;
    desc_t          new_desc;
    desc_t          head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [4:0]     count;
    logic           ovf;
    logic           err;
    logic [31:0]    perf_rd;
    logic [31:0]    rd_mux;

    logic           hit;
    logic           wr_en;
    logic           rd_en;
    logic [7:0]     offset;
    logic           commit;
    logic           size_ok;
    logic           full;
    logic           empty;
    logic           done;
    logic           pop;
    logic           push;

    assign offset = system_bus_addr[7:0];
    assign hit    = system_bus_en && (system_bus_addr[31:8] == BASE_ADDR[31:8]);
    assign wr_en  = hit && system_bus_rdwr;
    assign rd_en  = hit && !system_bus_rdwr;
    assign commit = wr_en && (offset == 8'd24);

    assign full   = (count == 5'(QDEPTH));
    assign empty  = (count == 5'd0);
    assign done   = empty && !gemm_busy;
    assign pop    = cmd_valid && cmd_ready;

    // Assemble the descriptor a DIM write would commit and validate its sizes
    always_comb begin
        new_desc       = stage;
        new_desc.msize = system_bus_wr_data[4:0];
        new_desc.ksize = system_bus_wr_data[9:5];
        new_desc.nsize = system_bus_wr_data[14:10];
        size_ok = (new_desc.msize != 5'd0) && (new_desc.msize <= 5'd16) &&
                  (new_desc.ksize != 5'd0) && (new_desc.ksize <= 5'd16) &&
                  (new_desc.nsize != 5'd0) && (new_desc.nsize <= 5'd16);
        push = commit && size_ok && (!full || pop);
    end

    // Staging registers capture address/stride/control writes and hold them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= '0;
        end else if (wr_en) begin
            case (offset)
                8'd0:  stage.a_addr   <= system_bus_wr_data;
                8'd4:  stage.b_addr   <= system_bus_wr_data;
                8'd8:  stage.c_addr   <= system_bus_wr_data;
                8'd12: stage.a_stride <= system_bus_wr_data;
                8'd16: stage.b_stride <= system_bus_wr_data;
                8'd20: begin
                    stage.first <= system_bus_wr_data[1];
                    stage.last  <= system_bus_wr_data[0];
                end
                default: ;
            endcase
        end
    end

    // Descriptor FIFO: push on a valid commit, pop on an engine handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_desc;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: ;
            endcase
        end
    end

    // Sticky overflow/error flags, cleared by any write to the status word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else if (wr_en && offset == 8'd28) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else if (commit) begin
            if (!size_ok)
                err <= 1'b1;
            else if (full && !pop)
                ovf <= 1'b1;
        end
    end

`ifdef GEMM_CMD_PERF_EN
    logic [31:0] perf_cnt;

    // Busy-cycle counter: restarts on a commit into an idle engine, runs until done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_cnt <= '0;
        else if (commit && done)
            perf_cnt <= '0;
        else if (!done)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_rd = perf_cnt;
`else
    assign perf_rd = '0;
`endif

    // Read mux; only a few offsets are readable, everything else returns 0
    always_comb begin
        rd_mux = '0;
        case (offset)
            8'd0:    rd_mux = {31'b0, full};
            8'd24:   rd_mux = {31'b0, done};
            8'd28:   rd_mux = {19'b0, count, 6'b0, ovf, err};
            8'd32:   rd_mux = perf_rd;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, updated on any read strobe and held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            system_bus_rd_data <= '0;
        else if (system_bus_en && !system_bus_rdwr)
            system_bus_rd_data <= rd_en ? rd_mux : 32'd0;
    end

    assign head         = mem[rd_ptr];
    assign cmd_valid    = !empty;
    assign cmd_a_addr   = head.a_addr;
    assign cmd_b_addr   = head.b_addr;
    assign cmd_c_addr   = head.c_addr;
    assign cmd_a_stride = head.a_stride;
    assign cmd_b_stride = head.b_stride;
    assign cmd_first    = head.first;
    assign cmd_last     = head.last;
    assign cmd_msize    = head.msize;
    assign cmd_ksize    = head.ksize;
    assign cmd_nsize    = head.nsize;

endmodule

// File: doc/gemm_bus_slave.md
GEMM_BUS_SLAVE -- requirements
Module: gemm_bus_slave

Interface
REQ-001 SHALL expose parameter BASE_ADDR, default 32'h9000_0000, base of the 256-byte register window.
REQ-002 SHALL expose parameter QDEPTH, default 4, tile-descriptor queue depth (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port system_bus_en, input, 1, bus access strobe.
REQ-006 SHALL have port system_bus_rdwr, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port system_bus_addr, input, 32, byte address.
REQ-008 SHALL have port system_bus_wr_data, input, 32, write data.
REQ-009 SHALL have port system_bus_rd_data, output, 32, registered read data.
REQ-010 SHALL have port cmd_valid, output, 1, head descriptor valid.
REQ-011 SHALL have port cmd_ready, input, 1, engine accepts head descriptor.
REQ-012 SHALL have ports cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_a_stride, cmd_b_stride, each output, 32, descriptor fields.
REQ-013 SHALL have ports cmd_first and cmd_last, output, 1 each, accumulate-start and writeback flags.
REQ-014 SHALL have ports cmd_msize, cmd_ksize, cmd_nsize, output, 5 each, tile dimensions.
REQ-015 SHALL have port gemm_busy, input, 1, engine still computing or writing C.

Function
REQ-016 Decode SHALL hit only when system_bus_en=1 and system_bus_addr[31:8]==BASE_ADDR[31:8]; offset = addr[7:0].
REQ-017 Write offsets SHALL be: 0 A addr, 4 B addr, 8 C addr, 12 A stride, 16 B stride, 20 control {bit1 first, bit0 last}, 24 DIM {msize[4:0], ksize[9:5], nsize[14:10]}.
REQ-018 Each write SHALL update its staging register in the same edge; staging registers SHALL hold until overwritten.
REQ-019 A write to offset 24 SHALL commit one descriptor: the current staging registers plus the DIM fields from that write's data.
REQ-020 A commit SHALL push when the queue is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 A commit with the queue full and no pop SHALL be dropped and SHALL set sticky status bit OVF.
REQ-022 A commit with any size field 0 or >16 SHALL be dropped and SHALL set sticky status bit ERR.
REQ-023 A pop SHALL occur when cmd_valid && cmd_ready; cmd_valid SHALL equal !empty; cmd_* SHALL show the queue head combinationally from storage.
REQ-024 Read data SHALL appear on system_bus_rd_data on the cycle after the read request (1-cycle latency) and SHALL hold until the next read.
REQ-025 Read offset 0 SHALL return {31'b0, full}.
REQ-026 Read offset 24 SHALL return {31'b0, done}, where done = empty && !gemm_busy.
REQ-027 Read offset 28 SHALL return {count[4:0] in bits 12:8, OVF bit1, ERR bit0}; a write of any value to offset 28 SHALL clear OVF and ERR.
REQ-028 Reads of unmapped offsets, or with no decode hit, SHALL return 0; such writes SHALL be ignored.
REQ-029 Queue pointers SHALL wrap modulo QDEPTH; the count SHALL stay in 0..QDEPTH.

Reset
REQ-030 While rst=0, SHALL clear the queue, staging registers, OVF, ERR and system_bus_rd_data; cmd_valid SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued descriptors; no pop or commit SHALL occur until the first rising edge after deassertion.

Configuration
REQ-032 With GEMM_CMD_PERF_EN defined, a 32-bit counter SHALL clear on a commit that finds done=1, increment each cycle while done=0, and freeze when done=1; offset 32 SHALL read the counter.
REQ-033 Without GEMM_CMD_PERF_EN, no counter SHALL exist and offset 32 SHALL read 0.

Verification
REQ-034 Write A=0, B=10000, C=20000, strides 100/100, ctrl=2'b10, DIM=16|16<<5|16<<10 with cmd_ready=0 -> cmd_valid=1 next cycle; fields match; offset-28 count = 1.
REQ-035 Five commits with cmd_ready=0 -> offset 0 reads 1 after the fourth commit; the fifth sets OVF; the queue holds the first four, in order.
REQ-036 Queue full, with a commit and cmd_ready=1 in the same cycle -> count stays 4; OVF stays 0; the new descriptor lands at the tail.
REQ-037 DIM write with msize=0 -> no push; ERR=1; writing offset 28 clears it.
REQ-038 Queue empty, gemm_busy 1->0 -> offset 24 reads 0 then 1; with GEMM_CMD_PERF_EN, offset 32 equals the cycles from the first commit to done.
REQ-039 rst pulsed low with 3 queued -> cmd_valid=0 immediately; after release, offset-28 count = 0.
